// File: rtl/trans_load_ctrl_pkg.sv
// Shared types and AXI constants for the TRANS operand load controller.
package trans_load_ctrl_pkg;

    typedef enum logic [1:0] {
        TYPE_FP32 = 2'd0,
        TYPE_FP16 = 2'd1,
        TYPE_INT8 = 2'd2,
        TYPE_INT4 = 2'd3
    } type_t;

    typedef enum logic [1:0] {
        MAT_A = 2'd0,
        MAT_B = 2'd1,
        MAT_C = 2'd2
    } mat_t;

    typedef logic [1:0] rc_t;
    localparam rc_t RC_M32N8  = 2'b00;
    localparam rc_t RC_M16N16 = 2'b01;
    localparam rc_t RC_M8N32  = 2'b10;
    localparam rc_t RC_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [2:0] AXI_SIZE_256   = 3'b101;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Beats per matrix burst; C is always 32 regardless of type.
    function automatic logic [5:0] beat_count(input mat_t mat, input type_t ty);
        logic [5:0] n;
        case (mat)
            MAT_A:   n = (ty == TYPE_FP32) ? 6'd16 : 6'd8;
            MAT_B:   n = (ty == TYPE_FP32) ? 6'd8  : 6'd16;
            default: n = 6'd32;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/trans_load_ctrl.sv
// Issues one AXI INCR read burst per enabled operand matrix (A, B, C order)
// and forwards each accepted R beat, registered, to the TRANS repacker.
module trans_load_ctrl
    import trans_load_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  type_t             cfg_type,
    input  rc_t               cfg_rc,
    input  logic [2:0]        cfg_mask,
    input  logic [ADDR_W-1:0] cfg_addr_a,
    input  logic [ADDR_W-1:0] cfg_addr_b,
    input  logic [ADDR_W-1:0] cfg_addr_c,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [DATA_W-1:0] t_data_in,
    output logic [4:0]        t_burst_num,
    output mat_t              t_mat,
    output type_t             t_type,
    output rc_t               t_rc,
    output logic              t_valid
);

    state_t            state_q, state_d;
    mat_t              mat_q, mat_d;
    logic [4:0]        cnt_q, cnt_d;
    type_t             type_q;
    rc_t               rc_q;
    logic [2:0]        mask_q;
    logic [ADDR_W-1:0] addr_a_q, addr_b_q, addr_c_q;
    logic              err_q, done_q;
    logic              tv_q;
    logic [DATA_W-1:0] tdata_q;
    logic [4:0]        tburst_q;
    mat_t              tmat_q;

    logic       start_acc;
    logic       rc_bad;
    logic [4:0] last_idx;
    logic       beat_fire;
    logic       beat_last;
    logic       beat_bad;
    logic       fwd;
    logic       has_next;
    mat_t       nxt_mat;
    mat_t       first_mat;

    assign start_acc = (state_q == S_IDLE) && start;
    assign rc_bad    = (cfg_rc == RC_RSVD) && (cfg_mask[1] || cfg_mask[2]);
    assign last_idx  = 5'(beat_count(mat_q, type_q) - 6'd1);
    assign beat_fire = (state_q == S_R) && rvalid;
    assign beat_last = (cnt_q == last_idx);
    assign beat_bad  = (rresp != AXI_RESP_OKAY) || (rlast != beat_last);
    assign fwd       = beat_fire && (rresp == AXI_RESP_OKAY);

    always_comb begin
        first_mat = MAT_A;
        if (cfg_mask[0])      first_mat = MAT_A;
        else if (cfg_mask[1]) first_mat = MAT_B;
        else if (cfg_mask[2]) first_mat = MAT_C;
    end

    // Next enabled matrix strictly after the one currently loading.
    always_comb begin
        has_next = 1'b0;
        nxt_mat  = MAT_A;
        if (mat_q == MAT_A) begin
            if (mask_q[1]) begin
                has_next = 1'b1;
                nxt_mat  = MAT_B;
            end else if (mask_q[2]) begin
                has_next = 1'b1;
                nxt_mat  = MAT_C;
            end
        end else if (mat_q == MAT_B && mask_q[2]) begin
            has_next = 1'b1;
            nxt_mat  = MAT_C;
        end
    end

    always_comb begin
        state_d = state_q;
        mat_d   = mat_q;
        cnt_d   = cnt_q;
        arvalid = 1'b0;
        araddr  = '0;
        arlen   = '0;
        rready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (rc_bad) begin
                        state_d = S_ERR;
                    end else if (cfg_mask == 3'b000) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_AR;
                        mat_d   = first_mat;
                    end
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                arlen   = {3'b000, last_idx};
                cnt_d   = '0;
                case (mat_q)
                    MAT_A:   araddr = addr_a_q;
                    MAT_B:   araddr = addr_b_q;
                    default: araddr = addr_c_q;
                endcase
                if (arready) state_d = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    cnt_d = cnt_q + 5'd1;
                    if (beat_bad) begin
                        state_d = S_ERR;
                    end else if (beat_last) begin
                        if (has_next) begin
                            state_d = S_AR;
                            mat_d   = nxt_mat;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mat_q    <= MAT_A;
            cnt_q    <= '0;
            type_q   <= TYPE_FP32;
            rc_q     <= '0;
            mask_q   <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            tv_q     <= 1'b0;
            tdata_q  <= '0;
            tburst_q <= '0;
            tmat_q   <= MAT_A;
        end else begin
            state_q <= state_d;
            mat_q   <= mat_d;
            cnt_q   <= cnt_d;
            // done trails the DONE state so it lands one cycle after the last t_valid.
            done_q  <= (state_q == S_DONE);
            if (start_acc) begin
                type_q   <= cfg_type;
                rc_q     <= cfg_rc;
                mask_q   <= cfg_mask;
                addr_a_q <= cfg_addr_a;
                addr_b_q <= cfg_addr_b;
                addr_c_q <= cfg_addr_c;
            end
            if (state_d == S_ERR)  err_q <= 1'b1;
            else if (start_acc)    err_q <= 1'b0;
            tv_q <= fwd;
            if (fwd) begin
                tdata_q  <= rdata;
                tburst_q <= cnt_q;
                tmat_q   <= mat_q;
            end
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign arsize      = AXI_SIZE_256;
    assign arburst     = AXI_BURST_INCR;
    assign t_valid     = tv_q;
    assign t_data_in   = tdata_q;
    assign t_burst_num = tburst_q;
    assign t_mat       = tmat_q;
    assign t_type      = type_q;
    assign t_rc        = rc_q;

endmodule

// File: tb/tb_trans_load_ctrl.sv
// Directed bench for trans_load_ctrl: bench acts as AXI slave, scoreboards TRANS beats.
module tb_trans_load_ctrl;
    import trans_load_ctrl_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    type_t             cfg_type = TYPE_FP32;
    rc_t               cfg_rc = '0;
    logic [2:0]        cfg_mask = '0;
    logic [ADDR_W-1:0] cfg_addr_a = '0, cfg_addr_b = '0, cfg_addr_c = '0;
    logic              busy, done, err;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready = 1'b0;
    logic [DATA_W-1:0] rdata = '0;
    logic [1:0]        rresp = '0;
    logic              rlast = 1'b0;
    logic              rvalid = 1'b0;
    logic              rready;
    logic [DATA_W-1:0] t_data_in;
    logic [4:0]        t_burst_num;
    mat_t              t_mat;
    type_t             t_type;
    rc_t               t_rc;
    logic              t_valid;

    always #5 clk = ~clk;

    trans_load_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_type(cfg_type), .cfg_rc(cfg_rc), .cfg_mask(cfg_mask),
        .cfg_addr_a(cfg_addr_a), .cfg_addr_b(cfg_addr_b), .cfg_addr_c(cfg_addr_c),
        .busy(busy), .done(done), .err(err),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .t_data_in(t_data_in), .t_burst_num(t_burst_num), .t_mat(t_mat),
        .t_type(t_type), .t_rc(t_rc), .t_valid(t_valid)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        int                burst;
        int                mat;
        int                cyc;
    } beat_t;

    beat_t exp_q[$];
    beat_t e;
    type_t m_type = TYPE_FP32;
    rc_t   m_rc = '0;
    int    vectors = 0, miscompares = 0;
    int    cyc = 0;
    int    tv_count = 0, last_tv_cyc = 0, last_burst = -1;
    int    done_cnt = 0, done_cyc = 0;
    int    ar_len_seen[3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic int model_beats(input int m, input type_t ty);
        if (m == 0) return (ty == TYPE_FP32) ? 16 : 8;
        if (m == 1) return (ty == TYPE_FP32) ? 8 : 16;
        return 32;
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every cycle: invariants, and each TRANS beat against the expected stream and arrival cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("done_and_err", {255'd0, done & err}, 256'd0);
            chk("arsize", arsize, AXI_SIZE_256);
            chk("arburst", arburst, AXI_BURST_INCR);
            if (t_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL t_valid_unexpected: got t_valid=1 burst=%0d, required no beat", t_burst_num);
                end else begin
                    e = exp_q.pop_front();
                    chk("t_cycle", cyc, e.cyc);
                    chk("t_data", t_data_in, e.data);
                    chk("t_burst_num", t_burst_num, e.burst);
                    chk("t_mat", t_mat, e.mat);
                    chk("t_type", t_type, m_type);
                    chk("t_rc", t_rc, m_rc);
                    tv_count++;
                    last_tv_cyc = cyc;
                    last_burst  = t_burst_num;
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL t_valid_missing: got t_valid=0, required beat %0d at cycle %0d", exp_q[0].burst, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic wait_arvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (arvalid) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        vectors++;
        miscompares++;
        $display("FAIL ar_timeout: got arvalid=0 for 20 cycles, required 1");
    endtask

    task automatic run_load(input type_t ty, input rc_t rc, input logic [2:0] mask,
                            input int ar_delay, input bit gaps, input int early_last,
                            input int bad_beat, input bit poke);
        bit                ok;
        bit                errored;
        int                nb;
        int                d0;
        logic [ADDR_W-1:0] addrs[3];
        logic [DATA_W-1:0] d;
        for (int m = 0; m < 3; m++) begin
            addrs[m] = 32'h1000_0000 + (m << 24) + ($urandom_range(0, 1023) << 5);
            ar_len_seen[m] = -1;
        end
        cfg_type = ty; cfg_rc = rc; cfg_mask = mask;
        cfg_addr_a = addrs[0]; cfg_addr_b = addrs[1]; cfg_addr_c = addrs[2];
        m_type = ty; m_rc = rc;
        errored = 1'b0;
        d0 = done_cnt;
        tv_count = 0;
        last_burst = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        if (rc == RC_RSVD && (mask[1] || mask[2])) begin
            chk("err_bad_rc", err, 1);
            for (int i = 0; i < 4; i++) begin
                chk("arvalid_bad_rc", arvalid, 0);
                tick();
            end
            chk("err_sticky", err, 1);
            chk("busy_end", busy, 0);
            chk("no_done_bad_rc", done_cnt, d0);
            return;
        end
        for (int m = 0; m < 3; m++) begin
            if (!mask[m] || errored) continue;
            nb = model_beats(m, ty);
            wait_arvalid(ok);
            if (!ok) return;
            chk("araddr", araddr, addrs[m]);
            chk("arlen", arlen, nb - 1);
            ar_len_seen[m] = arlen;
            for (int i = 0; i < ar_delay; i++) begin
                if (poke && i == 1) begin
                    start = 1'b1;
                    cfg_type = TYPE_FP32; cfg_mask = 3'b111;
                    cfg_addr_a = 32'hDEAD_0000; cfg_addr_b = 32'hDEAD_0020; cfg_addr_c = 32'hDEAD_0040;
                end
                tick();
                start = 1'b0;
                chk("arvalid_hold", arvalid, 1);
                chk("araddr_hold", araddr, addrs[m]);
                chk("arlen_hold", arlen, nb - 1);
            end
            arready = 1'b1;
            tick();
            arready = 1'b0;
            for (int b = 0; b < nb; b++) begin
                if (gaps && b > 0) begin
                    chk("rready_gap", rready, 1);
                    tick();
                end
                d = rand_data();
                rvalid = 1'b1;
                rdata  = d;
                rresp  = (b == bad_beat) ? 2'b10 : AXI_RESP_OKAY;
                rlast  = (b == nb - 1) || (b == early_last);
                chk("rready", rready, 1);
                if (rresp == AXI_RESP_OKAY) exp_q.push_back('{d, b, m, cyc + 1});
                tick();
                rvalid = 1'b0; rlast = 1'b0; rresp = AXI_RESP_OKAY;
                if (b == bad_beat || b == early_last) begin
                    errored = 1'b1;
                    break;
                end
            end
        end
        if (errored) begin
            chk("rready_after_err", rready, 0);
            chk("err_set", err, 1);
            chk("busy_in_err", busy, 1);
            tick();
            tick();
            chk("err_sticky", err, 1);
            chk("busy_end", busy, 0);
            chk("no_done_after_err", done_cnt, d0);
        end else begin
            for (int i = 0; i < 10 && done_cnt == d0; i++) tick();
            chk("done_seen", done_cnt, d0 + 1);
            if (tv_count > 0) chk("done_lag", done_cyc, last_tv_cyc + 1);
            chk("err_clear", err, 0);
            chk("busy_end", busy, 0);
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by 2000000 time units, required earlier finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        tick();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_t_valid", t_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // FP32, all three matrices, no backpressure.
        run_load(TYPE_FP32, RC_M32N8, 3'b111, 0, 1'b0, -1, -1, 1'b0);
        chk("t1_arlen_a", ar_len_seen[0], 15);
        chk("t1_arlen_b", ar_len_seen[1], 7);
        chk("t1_arlen_c", ar_len_seen[2], 31);
        chk("t1_beats", tv_count, 56);
        chk("t1_last_burst", last_burst, 31);

        // INT4 B only, AR held off 5 cycles, stray start while busy.
        run_load(TYPE_INT4, RC_M16N16, 3'b010, 5, 1'b0, -1, -1, 1'b1);
        chk("t2_arlen_b", ar_len_seen[1], 15);
        chk("t2_beats", tv_count, 16);

        // FP16 A with rvalid toggling.
        run_load(TYPE_FP16, RC_M8N32, 3'b001, 0, 1'b1, -1, -1, 1'b0);
        chk("t3_beats", tv_count, 8);
        chk("t3_last_burst", last_burst, 7);

        // INT8 C with rlast on beat 20.
        run_load(TYPE_INT8, RC_M32N8, 3'b100, 0, 1'b0, 20, -1, 1'b0);
        chk("t4_beats", tv_count, 21);
        chk("t4_last_burst", last_burst, 20);

        // SLVERR on beat 3 of A; B is skipped.
        run_load(TYPE_FP32, RC_M16N16, 3'b011, 0, 1'b0, -1, 3, 1'b0);
        chk("t5_beats", tv_count, 3);

        // Reserved shape with C enabled.
        run_load(TYPE_FP16, RC_RSVD, 3'b100, 0, 1'b0, -1, -1, 1'b0);

        // Empty mask completes immediately and clears err.
        run_load(TYPE_INT8, RC_M32N8, 3'b000, 0, 1'b0, -1, -1, 1'b0);
        chk("t7_beats", tv_count, 0);

        // Reset during beat 10 of B.
        cfg_type = TYPE_FP16; cfg_rc = RC_M16N16; cfg_mask = 3'b010;
        cfg_addr_b = 32'h2000_0040;
        m_type = TYPE_FP16; m_rc = RC_M16N16;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_arvalid(ok);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < 10; b++) begin
            rvalid = 1'b1;
            rdata  = rand_data();
            exp_q.push_back('{rdata, b, 1, cyc + 1});
            tick();
        end
        rvalid = 1'b1;
        rdata  = rand_data();
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_arvalid", arvalid, 0);
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_t_valid", t_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_araddr", araddr, 0);
        chk("mid_rst_burst", t_burst_num, 0);
        rvalid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", busy, 0);

        run_load(TYPE_INT4, RC_M32N8, 3'b001, 0, 1'b0, -1, -1, 1'b0);
        chk("t8_beats", tv_count, 8);
        chk("t8_last_burst", last_burst, 7);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
